arb_fifo: RTL and testbench

Buffering stage directly downstream of the two-slave arbiter. Captures each arbitrated word (data, mode, processing value, source tag) into a circular buffer, drives the `fifo_full` back-pressure the arbiter samples, and presents entries first-word-fall-through to the image-processing core over a valid/ready handshake. It also provides a flush for frame boundaries and a sticky overflow flag for debug.

---
 rtl/img_pkg.sv | 20 ++
 rtl/arb_fifo_mem.sv | 27 ++
 rtl/arb_fifo.sv | 111 +++++++++++
 tb/tb_arb_fifo.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// rtl/img_pkg.sv - shared pixel word types for the arbiter, buffer and processing core
package img_pkg;

    localparam int DW = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        M1   = 2'd1,
        M2   = 2'd2,
        M3   = 2'd3
    } mode_t;

    typedef struct packed {
        logic [DW-1:0] data;
        mode_t         mode;
        logic [7:0]    proc_val;
        logic          src;
    } pix_entry_t;

endpackage

// File: rtl/arb_fifo_mem.sv
// rtl/arb_fifo_mem.sv - entry storage with synchronous write and asynchronous read
module arb_fifo_mem
    import img_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  pix_entry_t    wdata,
    input  logic [AW-1:0] raddr,
    output pix_entry_t    rdata
);

    // Storage has no reset; validity is tracked entirely by the pointers and count.
    pix_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/arb_fifo.sv
// rtl/arb_fifo.sv - first-word-fall-through buffer between the arbiter and the processing core
module arb_fifo
    import img_pkg::*;
#(
    parameter int DW       = img_pkg::DW,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_valid,
    input  logic [DW-1:0]          wr_data,
    input  logic [1:0]             wr_mode,
    input  logic [7:0]             wr_proc_val,
    input  logic                   wr_src,
    input  logic                   flush,
    output logic                   fifo_full,
    output logic                   almost_full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [DW-1:0]          rd_data,
    output logic [1:0]             rd_mode,
    output logic [7:0]             rd_proc_val,
    output logic                   rd_src,
    output logic                   overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          overflow_q;
    logic          wr_attempt;
    logic          wr_fire;
    logic          rd_fire;
    pix_entry_t    wr_entry;
    pix_entry_t    head;

    // Fullness comes from the registered count, so a same-cycle pop never makes room.
    assign fifo_full   = (count_q == CW'(DEPTH));
    assign almost_full = (count_q >= CW'(AF_LEVEL));
    assign count       = count_q;
    assign rd_valid    = (count_q != '0);
    assign overflow    = overflow_q;

    assign wr_attempt = wr_valid && (wr_mode != 2'b00);
    assign wr_fire    = wr_attempt && !fifo_full && !flush;
    assign rd_fire    = rd_valid && rd_ready && !flush;

    assign wr_entry = '{data: wr_data, mode: mode_t'(wr_mode), proc_val: wr_proc_val, src: wr_src};

    arb_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_fire),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (head)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_attempt && fifo_full) begin
                overflow_q <= 1'b1;
            end
            if (flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count_q <= '0;
            end else begin
                if (wr_fire) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (rd_fire) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                case ({wr_fire, rd_fire})
                    2'b10:   count_q <= count_q + CW'(1);
                    2'b01:   count_q <= count_q - CW'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    // Empty buffer presents zeros rather than stale storage contents.
    always_comb begin
        rd_data     = '0;
        rd_mode     = 2'b00;
        rd_proc_val = '0;
        rd_src      = 1'b0;
        if (rd_valid) begin
            rd_data     = head.data;
            rd_mode     = head.mode;
            rd_proc_val = head.proc_val;
            rd_src      = head.src;
        end
    end

endmodule

// File: tb/tb_arb_fifo.sv
// tb/tb_arb_fifo.sv - randomized directed bench for arb_fifo against a queue model
module tb_arb_fifo;
    import img_pkg::*;

    localparam int DEPTH = 16;
    localparam int AFL   = DEPTH - 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic [31:0] wr_data = '0;
    logic [1:0]  wr_mode = '0;
    logic [7:0]  wr_proc_val = '0;
    logic        wr_src = 1'b0;
    logic        flush = 1'b0;
    logic        fifo_full;
    logic        almost_full;
    logic [4:0]  count;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [31:0] rd_data;
    logic [1:0]  rd_mode;
    logic [7:0]  rd_proc_val;
    logic        rd_src;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    pix_entry_t q[$];
    bit         m_ovf = 1'b0;

    always #5 clk = ~clk;

    arb_fifo #(.DW(32), .DEPTH(DEPTH), .AF_LEVEL(AFL)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_mode     (wr_mode),
        .wr_proc_val (wr_proc_val),
        .wr_src      (wr_src),
        .flush       (flush),
        .fifo_full   (fifo_full),
        .almost_full (almost_full),
        .count       (count),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_data     (rd_data),
        .rd_mode     (rd_mode),
        .rd_proc_val (rd_proc_val),
        .rd_src      (rd_src),
        .overflow    (overflow)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        pix_entry_t h;
        h = (q.size() != 0) ? q[0] : '0;
        chk({tag, ".count"}, 64'(count), 64'(q.size()));
        chk({tag, ".full"}, 64'(fifo_full), 64'(q.size() == DEPTH));
        chk({tag, ".afull"}, 64'(almost_full), 64'(q.size() >= AFL));
        chk({tag, ".rd_valid"}, 64'(rd_valid), 64'(q.size() != 0));
        chk({tag, ".rd_data"}, 64'(rd_data), 64'(h.data));
        chk({tag, ".rd_mode"}, 64'(rd_mode), 64'(h.mode));
        chk({tag, ".rd_pv"}, 64'(rd_proc_val), 64'(h.proc_val));
        chk({tag, ".rd_src"}, 64'(rd_src), 64'(h.src));
        chk({tag, ".overflow"}, 64'(overflow), 64'(m_ovf));
    endtask

    // One clock: drive inputs, let the model apply the rules to pre-edge state, compare after the edge.
    task automatic step(input string tag, input bit wv, input logic [31:0] d, input logic [1:0] m,
                        input logic [7:0] pv, input bit s, input bit rr, input bit fl);
        bit full, wf, rf;
        pix_entry_t e;
        wr_valid = wv; wr_data = d; wr_mode = m; wr_proc_val = pv; wr_src = s;
        rd_ready = rr; flush = fl;
        full = (q.size() == DEPTH);
        wf = wv && (m != 0) && !full && !fl;
        rf = (q.size() != 0) && rr && !fl;
        e = '{data: d, mode: mode_t'(m), proc_val: pv, src: s};
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            m_ovf = 1'b0;
        end else begin
            if (wv && (m != 0) && full) m_ovf = 1'b1;
            if (fl) q.delete();
            else begin
                if (rf) void'(q.pop_front());
                if (wf) q.push_back(e);
            end
        end
        #1;
        check_all(tag);
    endtask

    task automatic wr_rand(input string tag, input bit rr);
        step(tag, 1'b1, $urandom, 2'($urandom_range(1, 3)), 8'($urandom), 1'($urandom), rr, 1'b0);
    endtask

    task automatic idle(input string tag, input bit rr);
        step(tag, 1'b0, '0, 2'd0, '0, 1'b0, rr, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        idle("reset0", 1'b0);
        idle("reset1", 1'b0);
        rst_n = 1'b1;
        idle("post_reset", 1'b0);

        step("single_wr", 1'b1, 32'hA5A5_0001, 2'd1, 8'h10, 1'b0, 1'b0, 1'b0);
        idle("single_rd", 1'b1);
        idle("single_empty", 1'b0);

        for (int i = 0; i < DEPTH; i++) wr_rand("fill", 1'b0);
        wr_rand("overflow_wr", 1'b0);
        for (int i = 0; i < DEPTH; i++) idle("drain", 1'b1);

        for (int i = 0; i < 10; i++) wr_rand("wrap_w10", 1'b0);
        for (int i = 0; i < 10; i++) idle("wrap_r10", 1'b1);
        for (int i = 0; i < 12; i++)
            step("wrap_w12", 1'b1, 32'(i), 2'd2, 8'(i), 1'(i), 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) idle("wrap_r12", 1'b1);

        for (int i = 0; i < 5; i++) wr_rand("to5", 1'b0);
        for (int i = 0; i < 8; i++) wr_rand("simul5", 1'b1);
        for (int i = 0; i < 11; i++) wr_rand("to16", 1'b0);
        wr_rand("simul_full", 1'b1);
        for (int i = 0; i < 15; i++) idle("drain15", 1'b1);

        for (int i = 0; i < 7; i++) wr_rand("to7", 1'b0);
        step("flush", 1'b1, 32'hDEAD_BEEF, 2'd3, 8'h77, 1'b1, 1'b1, 1'b1);
        idle("after_flush", 1'b0);

        wr_rand("one", 1'b0);
        step("mode0", 1'b1, 32'h1234_5678, 2'd0, 8'h55, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) wr_rand("to9", 1'b0);
        rst_n = 1'b0;
        wr_rand("mid_reset", 1'b1);
        rst_n = 1'b1;
        idle("after_reset", 1'b0);

        for (int i = 0; i < 400; i++)
            step("soak", 1'($urandom), $urandom, 2'($urandom), 8'($urandom), 1'($urandom),
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 40) == 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
